cva6_pma_table: RTL

- Runtime-programmable physical memory attribute (PMA) table.
- Generalises the static cached / executable / non-idempotent region rules into NrRegions programmable entries, each with base, length, attribute byte and a lock bit.
- Sits beside the MMU/PMP path. Frontend, LSU and cache controllers send physical-address lookups over a valid/ready port and get registered attributes back one cycle later.
- Entries are reloaded from parameter defaults at reset.

---
 rtl/cva6_pma_pkg.sv | 32 +++
 rtl/cva6_pma_match.sv | 28 ++
 rtl/cva6_pma_table.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cva6_pma_pkg.sv
// Shared types and attribute-bit positions for the programmable PMA table.
package cva6_pma_pkg;

    localparam int unsigned PMA_AW = 64;

    localparam int unsigned ATTR_CACHE   = 1;
    localparam int unsigned ATTR_EXEC    = 2;
    localparam int unsigned ATTR_NONIDEM = 3;
    localparam int unsigned ATTR_LOCK    = 7;

    typedef enum logic [1:0] {
        CFG_BASE = 2'd0,
        CFG_LEN  = 2'd1,
        CFG_ATTR = 2'd2,
        CFG_RSVD = 2'd3
    } cfg_field_e;

    typedef struct packed {
        logic [PMA_AW-1:0] base;
        logic [PMA_AW-1:0] len;
        logic [7:0]        attr;
    } pma_entry_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] region;
        logic       cacheable;
        logic       exec;
        logic       nonidem;
    } pma_result_t;

endpackage

// File: rtl/cva6_pma_match.sv
// Single-entry comparator: true when the whole access lies inside an enabled region.
module cva6_pma_match
    import cva6_pma_pkg::*;
#(
    parameter int unsigned AddrWidth = 64
) (
    input  pma_entry_t           entry,
    input  logic [AddrWidth-1:0] addr,
    input  logic [1:0]           size,
    output logic                 match
);

    logic [AddrWidth:0] acc_bytes;
    logic [AddrWidth:0] acc_end;
    logic [AddrWidth:0] reg_end;

    // One extra bit keeps regions/accesses ending at 2^AddrWidth from wrapping.
    always_comb begin
        acc_bytes      = '0;
        acc_bytes[3:0] = 4'b0001 << size;
        acc_end        = {1'b0, addr} + acc_bytes;
        reg_end        = {1'b0, entry.base[AddrWidth-1:0]} + {1'b0, entry.len[AddrWidth-1:0]};
        match          = (entry.len[AddrWidth-1:0] != '0)
                      && (entry.base[AddrWidth-1:0] <= addr)
                      && (acc_end <= reg_end);
    end

endmodule

// File: rtl/cva6_pma_table.sv
// Runtime-programmable PMA table with a registered valid/ready lookup port and a config port.
module cva6_pma_table
    import cva6_pma_pkg::*;
#(
    parameter int unsigned NrRegions = 8,
    parameter int unsigned AddrWidth = 64,
    parameter logic [63:0] ResetBase [16] = '{0: 64'h8000_0000, 1: 64'h1_0000, default: 64'h0},
    parameter logic [63:0] ResetLen  [16] = '{0: 64'h4000_0000, 1: 64'h1_0000, 2: 64'h1000, default: 64'h0},
    parameter logic [7:0]  ResetAttr [16] = '{0: 8'h06, 1: 8'h04, 2: 8'h0C, default: 8'h00}
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [1:0]           req_size_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_hit_o,
    output logic [3:0]           rsp_region_o,
    output logic                 rsp_cacheable_o,
    output logic                 rsp_exec_o,
    output logic                 rsp_nonidem_o,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [3:0]           cfg_idx_i,
    input  logic [1:0]           cfg_field_i,
    input  logic [AddrWidth-1:0] cfg_wdata_i,
    output logic [AddrWidth-1:0] cfg_rdata_o,
    output logic                 cfg_err_o
);

    pma_entry_t            tbl [NrRegions];
    logic [NrRegions-1:0]  match_p0;
    pma_result_t           res_p0;
    pma_result_t           res_p1;
    logic                  vld_p1;
    logic                  accept_p0;

    pma_entry_t            sel_entry;
    logic                  idx_ok;
    logic                  field_ok;
    logic                  wr_ok;
    logic                  wr_bad;
    logic                  rd_bad;
    logic [AddrWidth-1:0]  rd_data;

    for (genvar g = 0; g < NrRegions; g++) begin : gen_match
        cva6_pma_match #(.AddrWidth(AddrWidth)) u_match (
            .entry (tbl[g]),
            .addr  (req_addr_i),
            .size  (req_size_i),
            .match (match_p0[g])
        );
    end

    // Lowest index wins: scan downward so the last assignment is the smallest hit.
    always_comb begin
        res_p0 = '0;
        for (int i = int'(NrRegions) - 1; i >= 0; i--) begin
            if (match_p0[i]) begin
                res_p0.hit       = 1'b1;
                res_p0.region    = 4'(i);
                res_p0.cacheable = tbl[i].attr[ATTR_CACHE];
                res_p0.exec      = tbl[i].attr[ATTR_EXEC];
                res_p0.nonidem   = tbl[i].attr[ATTR_NONIDEM];
            end
        end
    end

    assign req_ready_o = !vld_p1 || rsp_ready_i;
    assign accept_p0   = req_valid_i && req_ready_o;

    // Lookup stage p0 -> p1
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1 <= 1'b0;
            res_p1 <= '0;
        end else if (req_ready_o) begin
            vld_p1 <= req_valid_i;
            if (accept_p0) begin
                res_p1 <= res_p0;
            end
        end
    end

    assign rsp_valid_o     = vld_p1;
    assign rsp_hit_o       = res_p1.hit;
    assign rsp_region_o    = res_p1.region;
    assign rsp_cacheable_o = res_p1.cacheable;
    assign rsp_exec_o      = res_p1.exec;
    assign rsp_nonidem_o   = res_p1.nonidem;

    always_comb begin
        sel_entry = '0;
        for (int i = 0; i < int'(NrRegions); i++) begin
            if (cfg_idx_i == 4'(i)) begin
                sel_entry = tbl[i];
            end
        end
    end

    assign idx_ok   = {28'b0, cfg_idx_i} < NrRegions;
    assign field_ok = cfg_field_i != CFG_RSVD;
    assign wr_ok    = cfg_req_i && cfg_we_i && idx_ok && field_ok && !sel_entry.attr[ATTR_LOCK];
    assign wr_bad   = cfg_req_i && cfg_we_i && !(idx_ok && field_ok && !sel_entry.attr[ATTR_LOCK]);
    assign rd_bad   = cfg_req_i && !cfg_we_i && !(idx_ok && field_ok);

    always_comb begin
        rd_data = '0;
        if (idx_ok) begin
            case (cfg_field_e'(cfg_field_i))
                CFG_BASE: rd_data = sel_entry.base[AddrWidth-1:0];
                CFG_LEN:  rd_data = sel_entry.len[AddrWidth-1:0];
                CFG_ATTR: rd_data = AddrWidth'(sel_entry.attr);
                default:  rd_data = '0;
            endcase
        end
    end

    // Config stage: table update, read-back and error pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NrRegions); i++) begin
                tbl[i].base <= ResetBase[i];
                tbl[i].len  <= ResetLen[i];
                tbl[i].attr <= ResetAttr[i];
            end
            cfg_rdata_o <= '0;
            cfg_err_o   <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NrRegions); i++) begin
                if (wr_ok && cfg_idx_i == 4'(i)) begin
                    case (cfg_field_e'(cfg_field_i))
                        CFG_BASE: tbl[i].base <= PMA_AW'(cfg_wdata_i);
                        CFG_LEN:  tbl[i].len  <= PMA_AW'(cfg_wdata_i);
                        CFG_ATTR: tbl[i].attr <= cfg_wdata_i[7:0];
                        default:  ;
                    endcase
                end
            end
            if (cfg_req_i && !cfg_we_i) begin
                cfg_rdata_o <= rd_data;
            end
            cfg_err_o <= wr_bad || rd_bad;
        end
    end

endmodule
